rgb2yuv_downsampler: RTL and testbench

RGB2YUV_DOWNSAMPLER -- requirements
Module: rgb2yuv_downsampler

---
 rtl/rgb2yuv_downsampler_pkg.sv | 58 +++++
 rtl/rgb2yuv_downsampler_pixel_csc.sv | 32 +++
 rtl/rgb2yuv_downsampler.sv | 225 ++++++++++++++++++++++
 tb/tb_rgb2yuv_downsampler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb2yuv_downsampler_pkg.sv
// Shared types, default base addresses and colour-space coefficients for the
// RGB to YUV downsampler.
package rgb2yuv_downsampler_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CALC = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam int ADDR_W = 18;

  localparam int unsigned RGB_BASE_DEF   = 146944;
  localparam int unsigned Y_BASE_DEF     = 0;
  localparam int unsigned U_BASE_DEF     = 38400;
  localparam int unsigned V_BASE_DEF     = 57600;
  localparam int unsigned NUM_GROUPS_DEF = 19200;

  // Words read and written, and pixels converted, per 4-pixel group
  localparam int RD_WORDS    = 6;
  localparam int WR_WORDS    = 4;
  localparam int PIX_PER_GRP = 4;

  localparam int signed COEF_Y_R = 66;
  localparam int signed COEF_Y_G = 129;
  localparam int signed COEF_Y_B = 25;
  localparam int signed COEF_U_R = -38;
  localparam int signed COEF_U_G = -74;
  localparam int signed COEF_U_B = 112;
  localparam int signed COEF_V_R = 112;
  localparam int signed COEF_V_G = -94;
  localparam int signed COEF_V_B = -18;

  localparam int signed CSC_ROUND = 128;
  localparam int signed Y_OFFSET  = 16;
  localparam int signed UV_OFFSET = 128;

  // Saturate a signed result into an 8-bit sample
  function automatic logic [7:0] clip_u8(input logic signed [31:0] x);
    if (x < 0) begin
      return 8'd0;
    end else if (x > 255) begin
      return 8'd255;
    end else begin
      return x[7:0];
    end
  endfunction

  // Rounded mean of two 8-bit samples
  function automatic logic [7:0] avg_u8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + 9'd1;
    return s[8:1];
  endfunction

endpackage

// File: rtl/rgb2yuv_downsampler_pixel_csc.sv
// rgb2yuv_pixel_csc: converts one RGB pixel to clipped 8-bit Y, U, V.
// One product-sum unit per output channel; the top time-shares this single
// instance across the four pixels of a group.
module rgb2yuv_pixel_csc
  import rgb2yuv_downsampler_pkg::*;
(
  input  logic [7:0] r_i,
  input  logic [7:0] g_i,
  input  logic [7:0] b_i,
  output logic [7:0] y_o,
  output logic [7:0] u_o,
  output logic [7:0] v_o
);

  logic signed [31:0] r_s, g_s, b_s;
  logic signed [31:0] y_acc, u_acc, v_acc;

  assign r_s = $signed({24'd0, r_i});
  assign g_s = $signed({24'd0, g_i});
  assign b_s = $signed({24'd0, b_i});

  // Weighted sums with rounding, arithmetic shift, offset and saturation
  always_comb begin
    y_acc = COEF_Y_R * r_s + COEF_Y_G * g_s + COEF_Y_B * b_s + CSC_ROUND;
    u_acc = COEF_U_R * r_s + COEF_U_G * g_s + COEF_U_B * b_s + CSC_ROUND;
    v_acc = COEF_V_R * r_s + COEF_V_G * g_s + COEF_V_B * b_s + CSC_ROUND;
    y_o   = clip_u8((y_acc >>> 8) + Y_OFFSET);
    u_o   = clip_u8((u_acc >>> 8) + UV_OFFSET);
    v_o   = clip_u8((v_acc >>> 8) + UV_OFFSET);
  end

endmodule

// File: rtl/rgb2yuv_downsampler.sv
// rgb2yuv_downsampler: converts a packed-RGB frame in SRAM into planar Y and
// horizontally 2:1 subsampled U/V, one 4-pixel group at a time (14 cycles
// per group). Build option RGB2YUV_AVG_DS_EN: when defined each chroma pair
// is the rounded mean of both pixels, otherwise the even pixel is kept.
//
// state | meaning
// IDLE  | waiting for Enable
// RD    | issue the 6 RGB reads of the current group
// CALC  | convert one pixel per cycle as its read data has landed
// WR    | write {Y0,Y1}, {Y2,Y3}, U pair word, V pair word
// DONE  | one-cycle Enc_finish pulse, then back to IDLE
module rgb2yuv_downsampler
  import rgb2yuv_downsampler_pkg::*;
#(
  parameter int unsigned RGB_BASE   = RGB_BASE_DEF,
  parameter int unsigned Y_BASE     = Y_BASE_DEF,
  parameter int unsigned U_BASE     = U_BASE_DEF,
  parameter int unsigned V_BASE     = V_BASE_DEF,
  parameter int unsigned NUM_GROUPS = NUM_GROUPS_DEF
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                Enable,
  input  logic [15:0]         SRAM_read_data,
  output logic [15:0]         SRAM_write_data,
  output logic [ADDR_W-1:0]   SRAM_address,
  output logic                SRAM_we_n,
  output logic                Enc_finish
);

  localparam logic [ADDR_W-1:0] RGB_A    = ADDR_W'(RGB_BASE);
  localparam logic [ADDR_W-1:0] Y_A      = ADDR_W'(Y_BASE);
  localparam logic [ADDR_W-1:0] U_A      = ADDR_W'(U_BASE);
  localparam logic [ADDR_W-1:0] V_A      = ADDR_W'(V_BASE);
  localparam logic [ADDR_W-1:0] LAST_GRP = ADDR_W'(NUM_GROUPS - 1);

  state_e              state_q, state_d;
  logic [2:0]          step_q, step_d;
  logic [ADDR_W-1:0]   grp_q, grp_d;
  logic [ADDR_W-1:0]   rgb_addr_q, rgb_addr_d;

  // Read-return pipeline: which word index lands two cycles after issue
  logic                rp1_vld_q, rp2_vld_q;
  logic [2:0]          rp1_idx_q, rp2_idx_q;
  logic [15:0]         w_q [RD_WORDS];

  logic [7:0]          y_q  [PIX_PER_GRP];
  logic [7:0]          ue_q, ve_q;
  logic [7:0]          up_q [2];
  logic [7:0]          vp_q [2];

  logic [7:0]          pr, pg, pb;
  logic [7:0]          y_pix, u_pix, v_pix;
  logic [7:0]          u_pair, v_pair;

  // State and counter registers
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= IDLE;
      step_q     <= '0;
      grp_q      <= '0;
      rgb_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      grp_q      <= grp_d;
      rgb_addr_q <= rgb_addr_d;
    end
  end

  // Next-state and counter update; the RGB address only advances when another
  // group follows, so the last group never pushes it past the top of SRAM
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    grp_d      = grp_q;
    rgb_addr_d = rgb_addr_q;
    case (state_q)
      IDLE: begin
        if (Enable) begin
          state_d    = RD;
          step_d     = '0;
          grp_d      = '0;
          rgb_addr_d = RGB_A;
        end
      end
      RD: begin
        if (step_q == 3'(RD_WORDS - 1)) begin
          state_d = CALC;
          step_d  = '0;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      CALC: begin
        if (step_q == 3'(PIX_PER_GRP - 1)) begin
          state_d = WR;
          step_d  = '0;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      WR: begin
        if (step_q == 3'(WR_WORDS - 1)) begin
          step_d = '0;
          if (grp_q == LAST_GRP) begin
            state_d = DONE;
          end else begin
            state_d    = RD;
            grp_d      = grp_q + 1'b1;
            rgb_addr_d = rgb_addr_q + ADDR_W'(RD_WORDS);
          end
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Track outstanding reads and capture each word as it returns
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      rp1_vld_q <= 1'b0;
      rp2_vld_q <= 1'b0;
      rp1_idx_q <= '0;
      rp2_idx_q <= '0;
      for (int i = 0; i < RD_WORDS; i++) w_q[i] <= '0;
    end else begin
      rp1_vld_q <= (state_q == RD);
      rp1_idx_q <= step_q;
      rp2_vld_q <= rp1_vld_q;
      rp2_idx_q <= rp1_idx_q;
      if (rp2_vld_q) w_q[rp2_idx_q] <= SRAM_read_data;
    end
  end

  // Unpack the pixel converted this CALC step from the {R,G},{B,R},{G,B} words
  always_comb begin
    case (step_q[1:0])
      2'd0:    {pr, pg, pb} = {w_q[0], w_q[1][15:8]};
      2'd1:    {pr, pg, pb} = {w_q[1][7:0], w_q[2]};
      2'd2:    {pr, pg, pb} = {w_q[3], w_q[4][15:8]};
      default: {pr, pg, pb} = {w_q[4][7:0], w_q[5]};
    endcase
  end

  rgb2yuv_pixel_csc u_csc (
    .r_i (pr),
    .g_i (pg),
    .b_i (pb),
    .y_o (y_pix),
    .u_o (u_pix),
    .v_o (v_pix)
  );

  // Chroma pair formed on the odd pixel from the held even-pixel value
  always_comb begin
`ifdef RGB2YUV_AVG_DS_EN
    u_pair = avg_u8(ue_q, u_pix);
    v_pair = avg_u8(ve_q, v_pix);
`else
    u_pair = ue_q;
    v_pair = ve_q;
`endif
  end

  // Store Y per pixel, hold even-pixel chroma, store chroma pairs on odd pixels
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < PIX_PER_GRP; i++) y_q[i] <= '0;
      ue_q  <= '0;
      ve_q  <= '0;
      up_q[0] <= '0;
      up_q[1] <= '0;
      vp_q[0] <= '0;
      vp_q[1] <= '0;
    end else if (state_q == CALC) begin
      y_q[step_q[1:0]] <= y_pix;
      if (!step_q[0]) begin
        ue_q <= u_pix;
        ve_q <= v_pix;
      end else begin
        up_q[step_q[1]] <= u_pair;
        vp_q[step_q[1]] <= v_pair;
      end
    end
  end

  // SRAM bus and done pulse decoded from state; idle bus is all zeros
  always_comb begin
    SRAM_address    = '0;
    SRAM_write_data = '0;
    SRAM_we_n       = 1'b1;
    Enc_finish      = 1'b0;
    case (state_q)
      RD: SRAM_address = rgb_addr_q + ADDR_W'(step_q);
      WR: begin
        SRAM_we_n = 1'b0;
        case (step_q[1:0])
          2'd0: begin
            SRAM_address    = Y_A + (grp_q << 1);
            SRAM_write_data = {y_q[0], y_q[1]};
          end
          2'd1: begin
            SRAM_address    = Y_A + (grp_q << 1) + 1'b1;
            SRAM_write_data = {y_q[2], y_q[3]};
          end
          2'd2: begin
            SRAM_address    = U_A + grp_q;
            SRAM_write_data = {up_q[0], up_q[1]};
          end
          default: begin
            SRAM_address    = V_A + grp_q;
            SRAM_write_data = {vp_q[0], vp_q[1]};
          end
        endcase
      end
      DONE:    Enc_finish = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rgb2yuv_downsampler.sv
// Self-checking bench for rgb2yuv_downsampler with a small frame placed at the
// top of SRAM, so the last group reads the final six words of the address space.
module tb_rgb2yuv_downsampler;

  localparam int N     = 16;
  localparam int RGB_B = 262144 - 6 * N;
  localparam int Y_B   = 0;
  localparam int U_B   = 38400;
  localparam int V_B   = 57600;

`ifdef RGB2YUV_AVG_DS_EN
  localparam logic [15:0] RB_U = 16'h6D6D, RB_V = 16'hB8B8;
  localparam logic [15:0] MX_U = 16'h6D93, MX_V = 16'hB848;
`else
  localparam logic [15:0] RB_U = 16'h5A5A, RB_V = 16'hF0F0;
  localparam logic [15:0] MX_U = 16'h8036, MX_V = 16'h8022;
`endif

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        Enable = 1'b0;
  logic [15:0] SRAM_read_data, SRAM_write_data;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n, Enc_finish;

  int tests = 0;
  int fails = 0;

  bit [15:0]   mem [0:262143];
  logic [17:0] a1 = '0, a2 = '0, a3 = '0;
  int fin_cnt, wr_cnt, rd_cnt, bad_wr, rd_max, first_rd;
  bit rd_seen;

  typedef struct {
    logic [23:0] p0, p1, p2, p3;
    logic [15:0] y01, y23, uw, vw;
  } vec_t;
  vec_t vecs [6];

  always #5 Clock = ~Clock;

  rgb2yuv_downsampler #(
    .RGB_BASE   (RGB_B),
    .Y_BASE     (Y_B),
    .U_BASE     (U_B),
    .V_BASE     (V_B),
    .NUM_GROUPS (N)
  ) dut (
    .Clock           (Clock),
    .Resetn          (Resetn),
    .Enable          (Enable),
    .SRAM_read_data  (SRAM_read_data),
    .SRAM_write_data (SRAM_write_data),
    .SRAM_address    (SRAM_address),
    .SRAM_we_n       (SRAM_we_n),
    .Enc_finish      (Enc_finish)
  );

  // SRAM model: read data for an address appears two cycles later
  assign SRAM_read_data = mem[a3];

  always @(negedge Clock) begin : mon
    int ad;
    ad = int'(SRAM_address);
    a1 <= SRAM_address;
    a2 <= a1;
    a3 <= a2;
    if (Enc_finish) fin_cnt = fin_cnt + 1;
    if (!SRAM_we_n) begin
      wr_cnt = wr_cnt + 1;
      mem[SRAM_address] = SRAM_write_data;
      if (!((ad >= Y_B && ad < Y_B + 2 * N) || (ad >= U_B && ad < U_B + N) ||
            (ad >= V_B && ad < V_B + N)))
        bad_wr = bad_wr + 1;
    end else if (ad >= RGB_B) begin
      rd_cnt = rd_cnt + 1;
      if (!rd_seen) begin
        first_rd = ad;
        rd_seen  = 1'b1;
      end
      if (ad > rd_max) rd_max = ad;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference conversion straight from the colour equations
  function automatic int clip(input int x);
    return (x < 0) ? 0 : ((x > 255) ? 255 : x);
  endfunction

  function automatic int ref_y(input int r, input int g, input int b);
    return clip(((66 * r + 129 * g + 25 * b + 128) >>> 8) + 16);
  endfunction

  function automatic int ref_u(input int r, input int g, input int b);
    return clip(((-38 * r - 74 * g + 112 * b + 128) >>> 8) + 128);
  endfunction

  function automatic int ref_v(input int r, input int g, input int b);
    return clip(((112 * r - 94 * g - 18 * b + 128) >>> 8) + 128);
  endfunction

  function automatic int ref_pair(input int e, input int o);
`ifdef RGB2YUV_AVG_DS_EN
    return (e + o + 1) / 2;
`else
    return e + 0 * o;
`endif
  endfunction

  task automatic get_px(input int g, input int p, output int r, output int gg, output int b);
    int w;
    bit [15:0] w0, w1, w2;
    w  = RGB_B + 6 * g + 3 * (p / 2);
    w0 = mem[w];
    w1 = mem[w + 1];
    w2 = mem[w + 2];
    if (p % 2 == 0) begin
      r = int'(w0[15:8]); gg = int'(w0[7:0]); b = int'(w1[15:8]);
    end else begin
      r = int'(w1[7:0]); gg = int'(w2[15:8]); b = int'(w2[7:0]);
    end
  endtask

  task automatic check_model(input string tag);
    for (int g = 0; g < N; g++) begin
      int y[4], u[4], v[4];
      int r, gg, b;
      for (int p = 0; p < 4; p++) begin
        get_px(g, p, r, gg, b);
        y[p] = ref_y(r, gg, b);
        u[p] = ref_u(r, gg, b);
        v[p] = ref_v(r, gg, b);
      end
      chk($sformatf("%s_g%0d_y01", tag, g), 32'(mem[Y_B + 2 * g]), 32'(y[0] * 256 + y[1]));
      chk($sformatf("%s_g%0d_y23", tag, g), 32'(mem[Y_B + 2 * g + 1]), 32'(y[2] * 256 + y[3]));
      chk($sformatf("%s_g%0d_u", tag, g), 32'(mem[U_B + g]),
          32'(ref_pair(u[0], u[1]) * 256 + ref_pair(u[2], u[3])));
      chk($sformatf("%s_g%0d_v", tag, g), 32'(mem[V_B + g]),
          32'(ref_pair(v[0], v[1]) * 256 + ref_pair(v[2], v[3])));
    end
  endtask

  task automatic fill_groups(input logic [23:0] p0, input logic [23:0] p1,
                             input logic [23:0] p2, input logic [23:0] p3);
    for (int g = 0; g < N; g++) begin
      int b;
      b = RGB_B + 6 * g;
      mem[b]     = {p0[23:16], p0[15:8]};
      mem[b + 1] = {p0[7:0], p1[23:16]};
      mem[b + 2] = p1[15:0];
      mem[b + 3] = {p2[23:16], p2[15:8]};
      mem[b + 4] = {p2[7:0], p3[23:16]};
      mem[b + 5] = p3[15:0];
    end
  endtask

  task automatic fill_random();
    for (int a = RGB_B; a < 262144; a++) mem[a] = 16'($urandom);
  endtask

  // Start one frame (Enable pulsed or held), wait for it with a bound, then
  // check activity counts seen on the bus
  task automatic run_frame(input string tag, input bit hold);
    bit done;
    done = 1'b0;
    @(posedge Clock);
    for (int a = 0; a < 2 * N; a++) mem[Y_B + a] = 16'hDEAD;
    for (int a = 0; a < N; a++) begin
      mem[U_B + a] = 16'hDEAD;
      mem[V_B + a] = 16'hDEAD;
    end
    fin_cnt = 0; wr_cnt = 0; rd_cnt = 0; bad_wr = 0; rd_max = 0;
    first_rd = -1; rd_seen = 1'b0;
    @(negedge Clock);
    Enable = 1'b1;
    if (!hold) begin
      @(negedge Clock);
      Enable = 1'b0;
    end
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge Clock);
      if (Enc_finish) done = 1'b1;
    end
    if (hold) begin
      @(negedge Clock);
      Enable = 1'b0;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    repeat (30) @(negedge Clock);
    @(posedge Clock);
    chk({tag, "_finish_pulses"}, 32'(fin_cnt), 32'd1);
    chk({tag, "_writes"}, 32'(wr_cnt), 32'(4 * N));
    chk({tag, "_reads"}, 32'(rd_cnt), 32'(6 * N));
    chk({tag, "_bad_writes"}, 32'(bad_wr), 32'd0);
    chk({tag, "_first_rd"}, 32'(first_rd), 32'(RGB_B));
    chk({tag, "_last_rd"}, 32'(rd_max), 32'd262143);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : main
    bit found;
    vecs[0] = '{24'h000000, 24'h000000, 24'h000000, 24'h000000, 16'h1010, 16'h1010, 16'h8080, 16'h8080};
    vecs[1] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 16'hEBEB, 16'hEBEB, 16'h8080, 16'h8080};
    vecs[2] = '{24'hFF0000, 24'hFF0000, 24'hFF0000, 24'hFF0000, 16'h5252, 16'h5252, 16'h5A5A, 16'hF0F0};
    vecs[3] = '{24'hFF0000, 24'h000000, 24'hFF0000, 24'h000000, 16'h5210, 16'h5210, RB_U, RB_V};
    vecs[4] = '{24'h00FF00, 24'h00FF00, 24'h0000FF, 24'h0000FF, 16'h9090, 16'h2929, 16'h36F0, 16'h226E};
    vecs[5] = '{24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF, 16'hEB52, 16'h9029, MX_U, MX_V};

    repeat (3) @(negedge Clock);
    chk("rst_we_n", 32'(SRAM_we_n), 32'd1);
    chk("rst_addr", 32'(SRAM_address), 32'd0);
    chk("rst_wdata", 32'(SRAM_write_data), 32'd0);
    chk("rst_finish", 32'(Enc_finish), 32'd0);
    Resetn = 1'b1;
    repeat (2) @(negedge Clock);

    for (int k = 0; k < 6; k++) begin
      fill_groups(vecs[k].p0, vecs[k].p1, vecs[k].p2, vecs[k].p3);
      run_frame($sformatf("vec%0d", k), 1'b0);
      for (int g = 0; g < N; g++) begin
        chk($sformatf("vec%0d_g%0d_y01", k, g), 32'(mem[Y_B + 2 * g]), 32'(vecs[k].y01));
        chk($sformatf("vec%0d_g%0d_y23", k, g), 32'(mem[Y_B + 2 * g + 1]), 32'(vecs[k].y23));
        chk($sformatf("vec%0d_g%0d_u", k, g), 32'(mem[U_B + g]), 32'(vecs[k].uw));
        chk($sformatf("vec%0d_g%0d_v", k, g), 32'(mem[V_B + g]), 32'(vecs[k].vw));
      end
    end

    for (int k = 0; k < 2; k++) begin
      fill_random();
      run_frame($sformatf("rnd%0d", k), 1'b0);
      check_model($sformatf("rnd%0d", k));
    end

    // Enable held high through the whole frame and DONE: exactly one frame
    fill_random();
    run_frame("hold", 1'b1);
    check_model("hold");

    // Reset while writing group 5, then a clean restart from group 0
    fill_random();
    @(negedge Clock);
    Enable = 1'b1;
    @(negedge Clock);
    Enable = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge Clock);
      if (!SRAM_we_n && SRAM_address == 18'(Y_B + 10)) found = 1'b1;
    end
    chk("midrst_reached_wr", 32'(found), 32'd1);
    Resetn = 1'b0;
    #1;
    chk("midrst_we_n", 32'(SRAM_we_n), 32'd1);
    chk("midrst_addr", 32'(SRAM_address), 32'd0);
    chk("midrst_wdata", 32'(SRAM_write_data), 32'd0);
    chk("midrst_finish", 32'(Enc_finish), 32'd0);
    repeat (3) @(negedge Clock);
    Resetn = 1'b1;
    repeat (2) @(negedge Clock);
    run_frame("restart", 1'b0);
    check_model("restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
